// File: rtl/l1_data_array_nway.sv
// rtl/l1_data_array_nway.sv - N-way set-associative L1 data array with byte stores, refill merge and victim port
module l1_data_array_nway #(
   parameter int NWAY  = 4,
   parameter int NSET  = 32,
   parameter int LINE  = 512,
   parameter int WORD  = 32,
   parameter int WBITS = $clog2(NWAY),
   parameter int IBITS = $clog2(NSET),
   parameter int OBITS = $clog2(LINE/8)
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               rd_en,
   input  logic [IBITS-1:0]   rd_index,
   input  logic [OBITS-1:0]   rd_offset,
   input  logic [WBITS-1:0]   rd_way,
   output logic [WORD-1:0]    rd_data,
   output logic               rd_valid,
   input  logic               st_en,
   input  logic [IBITS-1:0]   st_index,
   input  logic [OBITS-1:0]   st_offset,
   input  logic [WBITS-1:0]   st_way,
   input  logic [WORD-1:0]    st_data,
   input  logic [WORD/8-1:0]  st_strb,
   input  logic               refill,
   input  logic [IBITS-1:0]   rf_index,
   input  logic [WBITS-1:0]   rf_way,
   input  logic [LINE-1:0]    rf_data,
   input  logic               ev_en,
   input  logic [IBITS-1:0]   ev_index,
   input  logic [WBITS-1:0]   ev_way,
   output logic [LINE-1:0]    ev_data,
   output logic               ev_valid
);

   localparam int WBYTES = WORD / 8;
   localparam int LBITS  = $clog2(WBYTES);
   localparam int NLINE  = NWAY * NSET;
   localparam int ABITS  = WBITS + IBITS;

   logic [LINE-1:0] mem_q [NLINE];

   logic [ABITS-1:0]       rd_addr, st_addr, rf_addr, ev_addr;
   logic [OBITS-LBITS-1:0] rd_word, st_word;
   logic [WORD-1:0]        st_bmask;
   logic [LINE-1:0]        st_mask, st_wdata, st_base, st_line, rd_line;
   logic                   st_wr;

   logic [WORD-1:0] rd_data_q, rd_data_d;
   logic            rd_valid_q;
   logic [LINE-1:0] ev_data_q;
   logic            ev_valid_q;

   logic unused_offset_bits;
   assign unused_offset_bits = ^{rd_offset[LBITS-1:0], st_offset[LBITS-1:0]};

   assign rd_addr = {rd_way, rd_index};
   assign st_addr = {st_way, st_index};
   assign rf_addr = {rf_way, rf_index};
   assign ev_addr = {ev_way, ev_index};

   // Misaligned offsets truncate to the enclosing word.
   assign rd_word = rd_offset[OBITS-1:LBITS];
   assign st_word = st_offset[OBITS-1:LBITS];

   always_comb begin
      st_bmask = '0;
      for (int b = 0; b < WBYTES; b++) begin
         st_bmask[b*8 +: 8] = {8{st_strb[b]}};
      end
   end

   assign st_mask  = {{(LINE-WORD){1'b0}}, st_bmask} << (st_word * WORD);
   assign st_wdata = {{(LINE-WORD){1'b0}}, st_data}  << (st_word * WORD);
   assign st_wr    = st_en && (|st_strb);

   // A same-cycle refill of the store line becomes the base the store bytes overlay.
   assign st_base = (refill && (rf_addr == st_addr)) ? rf_data : mem_q[st_addr];
   assign st_line = (st_base & ~st_mask) | (st_wdata & st_mask);

   // Word reads see this cycle's writes; victim reads do not.
   always_comb begin
      rd_line = mem_q[rd_addr];
      if (st_wr && (st_addr == rd_addr)) begin
         rd_line = st_line;
      end else if (refill && (rf_addr == rd_addr)) begin
         rd_line = rf_data;
      end
   end

   assign rd_data_d = rd_line[rd_word*WORD +: WORD];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NLINE; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (refill) mem_q[rf_addr] <= rf_data;
         if (st_wr)  mem_q[st_addr] <= st_line;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ev_data_q  <= '0;
         ev_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         ev_valid_q <= ev_en;
         if (rd_en) rd_data_q <= rd_data_d;
         if (ev_en) ev_data_q <= mem_q[ev_addr];
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign ev_data  = ev_data_q;
   assign ev_valid = ev_valid_q;

endmodule

// File: tb/tb_l1_data_array_nway.sv
// tb/tb_l1_data_array_nway.sv - scoreboard bench for l1_data_array_nway
module tb_l1_data_array_nway;

   localparam int IBITS = 5;
   localparam int WBITS = 2;
   localparam int OBITS = 6;
   localparam int LINE  = 512;
   localparam int WORD  = 32;

   logic              clk = 1'b0;
   logic              nrst;
   logic              rd_en;
   logic [IBITS-1:0]  rd_index;
   logic [OBITS-1:0]  rd_offset;
   logic [WBITS-1:0]  rd_way;
   logic [WORD-1:0]   rd_data;
   logic              rd_valid;
   logic              st_en;
   logic [IBITS-1:0]  st_index;
   logic [OBITS-1:0]  st_offset;
   logic [WBITS-1:0]  st_way;
   logic [WORD-1:0]   st_data;
   logic [3:0]        st_strb;
   logic              refill;
   logic [IBITS-1:0]  rf_index;
   logic [WBITS-1:0]  rf_way;
   logic [LINE-1:0]   rf_data;
   logic              ev_en;
   logic [IBITS-1:0]  ev_index;
   logic [WBITS-1:0]  ev_way;
   logic [LINE-1:0]   ev_data;
   logic              ev_valid;

   int checks = 0;
   int errors = 0;

   logic [WORD-1:0] rd_q [$];
   logic [LINE-1:0] ev_q [$];
   logic [WORD-1:0] last_rd;

   always #5 clk = ~clk;

   l1_data_array_nway dut (
      .clk(clk), .nrst(nrst),
      .rd_en(rd_en), .rd_index(rd_index), .rd_offset(rd_offset), .rd_way(rd_way),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .st_en(st_en), .st_index(st_index), .st_offset(st_offset), .st_way(st_way),
      .st_data(st_data), .st_strb(st_strb),
      .refill(refill), .rf_index(rf_index), .rf_way(rf_way), .rf_data(rf_data),
      .ev_en(ev_en), .ev_index(ev_index), .ev_way(ev_way),
      .ev_data(ev_data), .ev_valid(ev_valid)
   );

   function automatic logic [LINE-1:0] mk_line(input logic [WORD-1:0] base, input bit inc);
      logic [LINE-1:0] l;
      for (int k = 0; k < LINE/WORD; k++) l[k*WORD +: WORD] = inc ? base + WORD'(k) : base;
      return l;
   endfunction

   task automatic idle();
      rd_en = 0; st_en = 0; refill = 0; ev_en = 0;
      rd_index = 0; rd_offset = 0; rd_way = 0;
      st_index = 0; st_offset = 0; st_way = 0; st_data = 0; st_strb = 0;
      rf_index = 0; rf_way = 0; rf_data = 0;
      ev_index = 0; ev_way = 0;
   endtask

   task automatic issue_rd(input int idx, input int way, input int off, input logic [WORD-1:0] exp);
      rd_en = 1; rd_index = IBITS'(idx); rd_way = WBITS'(way); rd_offset = OBITS'(off);
      rd_q.push_back(exp);
   endtask

   task automatic issue_ev(input int idx, input int way, input logic [LINE-1:0] exp);
      ev_en = 1; ev_index = IBITS'(idx); ev_way = WBITS'(way);
      ev_q.push_back(exp);
   endtask

   task automatic do_refill(input int idx, input int way, input logic [LINE-1:0] d);
      refill = 1; rf_index = IBITS'(idx); rf_way = WBITS'(way); rf_data = d;
   endtask

   task automatic do_store(input int idx, input int way, input int off,
                           input logic [WORD-1:0] d, input logic [3:0] strb);
      st_en = 1; st_index = IBITS'(idx); st_way = WBITS'(way); st_offset = OBITS'(off);
      st_data = d; st_strb = strb;
   endtask

   // Advance one clock, then score the outputs against what was queued for this edge.
   task automatic tick(input string name);
      logic [WORD-1:0] er;
      logic [LINE-1:0] ee;
      bit rp, ep;
      rp = rd_en; ep = ev_en;
      @(posedge clk); #1;
      checks++;
      if (rd_valid !== rp) begin errors++; $display("FAIL %s rd_valid got %b want %b", name, rd_valid, rp); end
      checks++;
      if (ev_valid !== ep) begin errors++; $display("FAIL %s ev_valid got %b want %b", name, ev_valid, ep); end
      if (rp) begin
         er = rd_q.pop_front();
         checks++;
         if (rd_data !== er) begin errors++; $display("FAIL %s rd_data got %h want %h", name, rd_data, er); end
         last_rd = er;
      end else begin
         checks++;
         if (rd_data !== last_rd) begin errors++; $display("FAIL %s rd_data_hold got %h want %h", name, rd_data, last_rd); end
      end
      if (ep) begin
         ee = ev_q.pop_front();
         checks++;
         if (ev_data !== ee) begin errors++; $display("FAIL %s ev_data got %h want %h", name, ev_data, ee); end
      end
      idle();
   endtask

   task automatic test_reset();
      checks++;
      if (rd_valid !== 1'b0 || ev_valid !== 1'b0 || rd_data !== '0 || ev_data !== '0) begin
         errors++; $display("FAIL reset_outputs got %b %b %h want 0 0 0", rd_valid, ev_valid, rd_data);
      end
      issue_rd(0, 0, 0, 32'h0);
      issue_ev(31, 3, '0);
      tick("reset_read");
   endtask

   task automatic test_refill_read();
      do_refill(5, 2, mk_line(32'h1000_0000, 1));
      tick("refill");
      issue_rd(5, 2, 'h3C, 32'h1000_000F);
      tick("read_3c");
      issue_rd(5, 2, 'h3E, 32'h1000_000F);
      tick("read_3e_trunc");
      tick("read_idle_hold");
   endtask

   task automatic test_store();
      logic [LINE-1:0] l;
      do_store(5, 2, 'h08, 32'hAABB_CCDD, 4'b0101);
      tick("store");
      issue_rd(5, 2, 'h08, 32'h10BB_00DD);
      tick("store_read");
      do_store(5, 2, 'h10, 32'h1234_5678, 4'b1111);
      issue_rd(5, 2, 'h11, 32'h1234_5678);
      tick("store_write_first");
      do_store(5, 2, 'h14, 32'hDEAD_BEEF, 4'b0000);
      tick("store_strb0");
      l = mk_line(32'h1000_0000, 1);
      l[2*WORD +: WORD] = 32'h10BB_00DD;
      l[4*WORD +: WORD] = 32'h1234_5678;
      issue_ev(5, 2, l);
      tick("store_line");
      for (int w = 0; w < 4; w++) begin
         if (w != 2) begin
            issue_ev(5, w, '0);
            issue_rd(5, w, 'h08, 32'h0);
            tick("other_way");
         end
      end
   endtask

   task automatic test_same_cycle_merge();
      logic [LINE-1:0] l;
      do_refill(7, 1, mk_line(32'h5555_5555, 0));
      do_store(7, 1, 'h04, 32'hFFFF_FFFF, 4'b1000);
      tick("merge");
      l = mk_line(32'h5555_5555, 0);
      l[1*WORD +: WORD] = 32'hFF55_5555;
      issue_ev(7, 1, l);
      issue_rd(7, 1, 'h04, 32'hFF55_5555);
      tick("merge_line");
      do_refill(8, 0, mk_line(32'h8800_0000, 1));
      do_store(7, 1, 'h3C, 32'h0123_4567, 4'b0011);
      tick("refill_store_diff");
      issue_rd(8, 0, 'h20, 32'h8800_0008);
      tick("diff_refill");
      issue_rd(7, 1, 'h3C, 32'h5555_4567);
      tick("diff_store");
   endtask

   task automatic test_back_to_back();
      logic [LINE-1:0] a, b;
      a = mk_line(32'hA0A0_0000, 1);
      b = mk_line(32'hB0B0_0000, 1);
      do_refill(9, 0, a);
      tick("load_a");
      issue_ev(9, 0, a);
      do_refill(9, 0, b);
      issue_rd(9, 0, 0, 32'hB0B0_0000);
      tick("evict_refill");
      issue_ev(9, 0, b);
      issue_rd(9, 0, 'h3C, 32'hB0B0_000F);
      tick("evict_after");
   endtask

   task automatic test_reset_mid();
      issue_rd(9, 0, 0, 32'h0);
      issue_ev(9, 0, '0);
      nrst = 0;
      @(posedge clk); #1;
      nrst = 1;
      rd_q.delete(); ev_q.delete();
      checks++;
      if (rd_valid !== 1'b0 || ev_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mid_valid got %b %b want 0 0", rd_valid, ev_valid);
      end
      last_rd = '0;
      idle();
      issue_rd(9, 0, 'h3C, 32'h0);
      issue_ev(9, 0, '0);
      tick("post_reset_9");
      issue_rd(5, 2, 'h08, 32'h0);
      issue_ev(7, 1, '0);
      tick("post_reset_5_7");
      issue_rd(8, 0, 'h20, 32'h0);
      issue_ev(5, 2, '0);
      tick("post_reset_8");
   endtask

   initial begin
      idle();
      last_rd = '0;
      nrst = 0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1;
      test_reset();
      test_refill_read();
      test_store();
      test_same_cycle_merge();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (rd_q.size() != 0 || ev_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got %0d %0d want 0 0", rd_q.size(), ev_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l1_data_array_nway.md
Name: l1_data_array_nway

Overview:
- Parametrised N-way set-associative L1 data array; successor to the fixed 2-way, read-only L1_I_data_array.
- Adds word stores with byte strobes and refill/store merging.
- Adds a victim-line read port for write-back to L2.
- Registered 1-cycle read with valid flags.
- Sits between the L1 controller (tag/LRU/FSM) and the L2 interface; usable for both L1_I and L1_D.

Parameters:
- NWAY, 4, number of ways (power of 2, ≥2)
- NSET, 32, sets per way (power of 2)
- LINE, 512, line width in bits (L2-L1 bus width)
- WORD, 32, CPU word width in bits (L1-core bus width)
- WBITS, $clog2(NWAY), way select width (derived)
- IBITS, $clog2(NSET), index width (derived)
- OBITS, $clog2(LINE/8), byte offset width (derived)

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- rd_en  in  1  word read request
- rd_index  in  IBITS  read set
- rd_offset  in  OBITS  read byte offset
- rd_way  in  WBITS  read way (hit way from tag array)
- rd_data  out  WORD  read word
- rd_valid  out  1  rd_data valid
- st_en  in  1  word store
- st_index  in  IBITS  store set
- st_offset  in  OBITS  store byte offset
- st_way  in  WBITS  store way
- st_data  in  WORD  store data
- st_strb  in  WORD/8  byte enables
- refill  in  1  full-line write from L2
- rf_index  in  IBITS  refill set
- rf_way  in  WBITS  refill way
- rf_data  in  LINE  refill line
- ev_en  in  1  victim line read request
- ev_index  in  IBITS  victim set
- ev_way  in  WBITS  victim way
- ev_data  out  LINE  victim line
- ev_valid  out  1  ev_data valid

Behaviour:
Reset:
- nrst=0 clears all NWAY*NSET lines to 0 asynchronously.
- rd_data=0, rd_valid=0, ev_data=0, ev_valid=0.
- Reset asserted mid-operation discards pending results; valids are 0 in the first cycle after release.

Addressing:
- Word select = offset[OBITS-1:$clog2(WORD/8)]; low offset bits are ignored (misaligned address truncates to the enclosing word).
- Word k occupies line bits [k*WORD +: WORD].

Write path (on posedge):
- refill=1 writes rf_data to line (rf_index, rf_way).
- st_en=1 writes bytes of st_data where st_strb[b]=1 into the selected word; unstrobed bytes are unchanged; st_strb=0 is a no-op.
- refill and st_en to different lines in the same cycle: both applied.
- refill and st_en to the same line in the same cycle: result is rf_data with the strobed store bytes overlaid (store wins per byte).

Read path (latency 1):
- rd_en at cycle T → rd_valid=1 and rd_data at T+1.
- rd_en=0 → rd_valid=0 next cycle; rd_data holds its last value.
- Write-first: if a refill or store hits the read line at T, rd_data at T+1 reflects the merged new contents.

Victim path (latency 1):
- ev_en at T → ev_valid=1 and ev_data at T+1.
- Read-first: returns the line contents before any write at T, so the controller can issue eviction and refill to the same way in one cycle.

Other rules:
- All read and victim requests may coincide with any writes. There is no stall and no backpressure; the controller owns sequencing.
- Out-of-range values are impossible by width.

Test Plan:
- Reset, then rd_en at (idx 0, way 0, off 0) → rd_valid=1 one cycle later, rd_data=0; ev_en (idx 31, way 3) → ev_data=0.
- Refill (idx 5, way 2) with line word k = 32'h1000_0000+k; next cycle read off 0x3C → 32'h1000_000F. Read off 0x3E → same word (truncation).
- Store 32'hAABB_CCDD, strb 4'b0101, to (idx 5, way 2, off 0x08) over word 32'h1000_0002 → read returns 32'h10BB_00DD. The other 3 ways of idx 5 are unchanged.
- Same-cycle refill (idx 7, way 1, all words 32'h5555_5555) plus store 32'hFFFF_FFFF, strb 4'b1000, off 0x04 → word 1 = 32'hFF55_5555; all other words 32'h5555_5555.
- Line at (idx 9, way 0) = pattern A. In the same cycle: ev_en, refill with pattern B, and rd_en of word 0 → ev_data=A, rd_data=B word 0. A following ev_en returns B.
- Assert nrst for 1 cycle while rd_en and ev_en are active → rd_valid=ev_valid=0 and all lines read back 0 after release.
